// File: rtl/tube_pkg.sv
// Shared constants, segment codes and FSM states for the six-digit tube scanner.
package tube_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned ITERS      = 24;
    localparam logic [23:0] MAX_VAL    = 24'd999_999;

    // Active-low segment codes, bit 7 is the decimal point (kept dark).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tube_scan_ctrl_if.sv
// Load handshake and tube pin bundle between a value producer and the scan controller.
interface tube_scan_ctrl_if;

    logic [tube_pkg::DATA_W-1:0]     load_data;
    logic                            load_valid;
    logic                            load_ready;
    logic                            busy;
    logic [tube_pkg::NUM_DIGITS-1:0] sel;
    logic [7:0]                      seg;

    modport master (
        output load_data, load_valid,
        input  load_ready, busy, sel, seg
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, busy, sel, seg
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle after start.
module bin2bcd_seq
    import tube_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [23:0]       bcd
);

    logic [47:0] sr_q, sr_d, adj;
    logic [4:0]  it_q, it_d;
    logic        active_q, active_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q     <= '0;
            it_q     <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            it_q     <= it_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        adj = sr_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr_q[DATA_W + 4*i +: 4] >= 4'd5) begin
                adj[DATA_W + 4*i +: 4] = sr_q[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sr_d     = sr_q;
        it_d     = it_q;
        active_d = active_q;
        if (start) begin
            sr_d     = {24'd0, data};
            it_d     = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            sr_d = {adj[46:0], 1'b0};
            it_d = it_q + 5'd1;
            if (it_q == 5'(ITERS - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    // Asserted during the final iteration so the caller can leave CONV on the same edge.
    assign done = active_q && (it_q == 5'(ITERS - 1));
    assign bcd  = sr_q[47:24];

endmodule

// File: rtl/tube_scan_ctrl.sv
// Six-digit seven-segment scan controller with valid/ready load and sequential BCD conversion.
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int unsigned SCAN_CNT = 50_000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    tube_scan_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_CNT > 2) ? $clog2(SCAN_CNT) : 1;

    state_e state_q, state_d;
    logic   load_ready, conv_start, commit, conv_done;

    logic [DATA_W-1:0] load_clamped;
    logic [23:0]       conv_bcd;

    logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0]      sel_q, sel_d;
    logic [7:0]                 seg_q, seg_d;
    logic                       running, tick, blank;

    assign load_clamped = (bus.load_data > MAX_VAL) ? MAX_VAL : bus.load_data;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .data  (load_clamped),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.load_valid) state_d = CONV;
            CONV:    if (conv_done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == IDLE);
        conv_start = load_ready && bus.load_valid;
        commit     = (state_q == COMMIT);
    end

    assign bus.load_ready = load_ready;
    assign bus.busy       = ~load_ready;

    // The counter holds for the one cycle in which sel comes out of reset so
    // that the first digit stays lit for a full SCAN_CNT period like the rest.
    always_comb begin
        running = (sel_q != '0);
        tick    = running && (cnt_q == CNT_W'(SCAN_CNT - 1));
        cnt_d   = (!running || tick) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        disp_d = commit ? conv_bcd : disp_q;
        sel_d  = NUM_DIGITS'(1) << idx_d;
    end

    // A position is blank when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            blank = (idx_d != 3'd0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i >= int'(idx_d) && disp_d[i] != 4'd0) begin
                    blank = 1'b0;
                end
            end
        end
        seg_d = blank ? SEG_BLANK : seg_code(disp_d[idx_d]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            sel_q  <= '0;
            seg_q  <= SEG_BLANK;
        end else begin
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;

endmodule
